mips_lsu: RTL and testbench

- Load/store initiator that drives the word-wide data RAM from the MEM stage of the MIPS pipeline.
- The RAM has a combinational read, a synchronous write, and no byte enables. This block therefore converts LB/LBU/LH/LHU/LW/SB/SH/SW requests into RAM cycles.
- SB/SH use a two-cycle read-modify-write (RMW). The block stalls the pipeline while an RMW is in progress and returns load data, extracted and extended, one cycle after acceptance.

---
 rtl/mips_lsu_pkg.sv | 19 +
 rtl/lsu_lane_merge.sv | 61 ++++++
 rtl/mips_lsu.sv | 177 +++++++++++++++++
 tb/tb_mips_lsu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg
// Shared constants for the MIPS load/store unit: access-size encodings,
// the FSM state type and the fixed data width.
package mips_lsu_pkg;

    localparam int LSU_WIDTH = 32;

    // req_size encodings; 2'b11 is illegal and handled as a word access
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_merge.sv
// lsu_lane_merge
// Purely combinational little-endian lane logic shared by the load path
// and the read-modify-write path.
//   ext_*  : extract a byte/half/word from ext_word and sign/zero-extend it
//   ins_*  : replace the addressed lane(s) of ins_old with right-aligned ins_data
// Half accesses select on lane[1] only; word accesses ignore the lane.
module lsu_lane_merge
    import mips_lsu_pkg::*;
(
    input  logic [31:0] ext_word,
    input  logic [1:0]  ext_lane,
    input  logic [1:0]  ext_size,
    input  logic        ext_signed,
    output logic [31:0] ext_data,
    input  logic [31:0] ins_old,
    input  logic [31:0] ins_data,
    input  logic [1:0]  ins_lane,
    input  logic [1:0]  ins_size,
    output logic [31:0] ins_word
);

    logic [7:0]  ext_byte;
    logic [15:0] ext_half;

    always_comb begin
        ext_byte = 8'h00;
        case (ext_lane)
            2'd0:    ext_byte = ext_word[7:0];
            2'd1:    ext_byte = ext_word[15:8];
            2'd2:    ext_byte = ext_word[23:16];
            default: ext_byte = ext_word[31:24];
        endcase
        ext_half = ext_lane[1] ? ext_word[31:16] : ext_word[15:0];

        case (ext_size)
            SIZE_BYTE: ext_data = {{24{ext_signed & ext_byte[7]}}, ext_byte};
            SIZE_HALF: ext_data = {{16{ext_signed & ext_half[15]}}, ext_half};
            default:   ext_data = ext_word;
        endcase
    end

    always_comb begin
        ins_word = ins_old;
        case (ins_size)
            SIZE_BYTE: begin
                case (ins_lane)
                    2'd0:    ins_word[7:0]   = ins_data[7:0];
                    2'd1:    ins_word[15:8]  = ins_data[7:0];
                    2'd2:    ins_word[23:16] = ins_data[7:0];
                    default: ins_word[31:24] = ins_data[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (ins_lane[1]) ins_word[31:16] = ins_data[15:0];
                else             ins_word[15:0]  = ins_data[15:0];
            end
            default: ins_word = ins_data;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// mips_lsu
// Load/store initiator driving a word-wide RAM (combinational read,
// synchronous write, no byte enables) from the MIPS MEM stage.
//   Loads  : one RAM read, extracted data registered on resp_rdata (latency 1).
//   SW     : single-cycle write, no stall.
//   SB/SH  : two-cycle read-modify-write; stall is high for both cycles and
//            the pipeline advances on the edge that commits the merged word.
// Ports: clk/rst (async, active-high); req_* MEM-stage request; stall;
//   resp_valid/resp_rdata load response; misalign trap flag; ram_* RAM side;
//   dbg_state exposes the FSM state for checkers.
// Handshake: a request is accepted on a rising edge where req_valid=1 and
//   the FSM is IDLE; while stall=1 the pipeline holds its request unchanged
//   and the block ignores it.
// Optional feature: define MISALIGN_TRAP_EN to flag misaligned half/word
//   requests (misalign pulses, no RAM access). Undefined: misalign is 0 and
//   low address bits are masked.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int WIDTH = LSU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [31:0]      req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             stall,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             misalign,
    output logic             ram_ena,
    output logic             ram_wena,
    output logic [DEPTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata,
    output lsu_state_e       dbg_state
);

    lsu_state_e       state_q, state_d;
    logic [DEPTH-1:0] cap_addr_q, cap_addr_d;
    logic [1:0]       cap_lane_q, cap_lane_d;
    logic [1:0]       cap_size_q, cap_size_d;
    logic [31:0]      cap_data_q, cap_data_d;
    logic [31:0]      merge_q, merge_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             misalign_q, misalign_d;

    logic             accept;
    logic             sub_store;
    logic             misaligned;
    logic [31:0]      ext_data;
    logic [31:0]      ins_word;

    // Upper address bits lie outside the RAM and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:DEPTH+2];

    // rst gates acceptance so the RAM sees no access while reset is held,
    // even if the pipeline keeps presenting a request.
    assign accept    = req_valid && !rst && (state_q == IDLE);
    assign sub_store = req_we && ((req_size == SIZE_BYTE) || (req_size == SIZE_HALF));

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        if (req_size == SIZE_HALF)      misaligned = req_addr[0];
        else if (req_size != SIZE_BYTE) misaligned = (req_addr[1:0] != 2'b00);
    end
`else
    assign misaligned = 1'b0;
`endif

    lsu_lane_merge u_lane_merge (
        .ext_word   (ram_rdata),
        .ext_lane   (req_addr[1:0]),
        .ext_size   (req_size),
        .ext_signed (req_signed),
        .ext_data   (ext_data),
        .ins_old    (ram_rdata),
        .ins_data   (cap_data_q),
        .ins_lane   (cap_lane_q),
        .ins_size   (cap_size_q),
        .ins_word   (ins_word)
    );

    always_comb begin
        state_d      = state_q;
        cap_addr_d   = cap_addr_q;
        cap_lane_d   = cap_lane_q;
        cap_size_d   = cap_size_q;
        cap_data_d   = cap_data_q;
        merge_d      = merge_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        misalign_d   = 1'b0;
        stall        = 1'b0;
        ram_ena      = 1'b0;
        ram_wena     = 1'b0;
        ram_addr     = req_addr[DEPTH+1:2];
        ram_wdata    = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else if (!req_we) begin
                        ram_ena      = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = ext_data;
                    end else if (sub_store) begin
                        stall      = 1'b1;
                        cap_addr_d = req_addr[DEPTH+1:2];
                        cap_lane_d = req_addr[1:0];
                        cap_size_d = req_size;
                        cap_data_d = req_wdata;
                        state_d    = RMW_RD;
                    end else begin
                        ram_ena   = 1'b1;
                        ram_wena  = 1'b1;
                        ram_wdata = req_wdata;
                    end
                end
            end
            RMW_RD: begin
                stall    = 1'b1;
                ram_ena  = 1'b1;
                ram_addr = cap_addr_q;
                merge_d  = ins_word;
                state_d  = RMW_WR;
            end
            RMW_WR: begin
                ram_ena   = 1'b1;
                ram_wena  = 1'b1;
                ram_addr  = cap_addr_q;
                ram_wdata = merge_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cap_addr_q   <= '0;
            cap_lane_q   <= '0;
            cap_size_q   <= '0;
            cap_data_q   <= '0;
            merge_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cap_addr_q   <= cap_addr_d;
            cap_lane_q   <= cap_lane_d;
            cap_size_q   <= cap_size_d;
            cap_data_q   <= cap_data_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            misalign_q   <= misalign_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign misalign   = misalign_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu
// Directed bench for mips_lsu with a behavioural word RAM. Load expectations
// are pushed into exp_q at issue time; a monitor pops and compares whenever
// resp_valid is seen. Combinational outputs and RAM contents are checked
// directly by the driver sequence.
module tb_mips_lsu;
    import mips_lsu_pkg::*;

    localparam int DEPTH = 10;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign;
    logic        ram_ena;
    logic        ram_wena;
    logic [DEPTH-1:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    lsu_state_e  dbg_state;

    logic [31:0] mem [0:(1<<DEPTH)-1];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          fails  = 0;

    mips_lsu #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .misalign   (misalign),
        .ram_ena    (ram_ena),
        .ram_wena   (ram_wena),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset / RAM model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_ena && ram_wena) mem[ram_addr] <= ram_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_resp: got resp_valid=1 data 0x%08h, expected no response", resp_rdata);
            end else begin
                check("resp_rdata", resp_rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] exp);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        exp_q.push_back(exp);
        #1;
        check("load_stall", {31'b0, stall}, 32'd0);
    endtask

    task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SIZE_WORD;
        req_addr  = addr;
        req_wdata = data;
        #1;
        check("sw_stall", {31'b0, stall}, 32'd0);
        check("sw_wena", {31'b0, ram_wena}, 32'd1);
    endtask

    // Holds the request while stall is high; returns in the cycle whose
    // closing edge commits the merged word.
    task automatic store_sub(input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] data);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = size;
        req_addr  = addr;
        req_wdata = data;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (!stall) break;
            n++;
            @(negedge clk);
        end
        check("rmw_stall_cycles", n, 32'd2);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < (1 << DEPTH); i++) mem[i] = 32'hA500_0000 | i;
        mem[4] = 32'h1122_3344;
        mem[5] = 32'h80FF_7F00;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = SIZE_WORD;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;

        repeat (2) @(negedge clk);
        check("rst_stall",      {31'b0, stall},      32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);
        check("rst_misalign",   {31'b0, misalign},   32'd0);
        check("rst_ram_ena",    {31'b0, ram_ena},    32'd0);
        check("rst_ram_wdata",  ram_wdata,           32'd0);
        check("rst_state",      {30'b0, dbg_state},  {30'b0, IDLE});
        rst = 1'b0;

        // Loads: lane extraction and extension
        load(32'h13, SIZE_BYTE, 1'b1, 32'h0000_0011);
        load(32'h10, SIZE_HALF, 1'b0, 32'h0000_3344);
        load(32'h16, SIZE_BYTE, 1'b1, 32'hFFFF_FFFF);
        load(32'h16, SIZE_BYTE, 1'b0, 32'h0000_00FF);
        load(32'h14, SIZE_HALF, 1'b1, 32'h0000_7F00);
        load(32'h16, SIZE_HALF, 1'b1, 32'hFFFF_80FF);
        load(32'h16, SIZE_HALF, 1'b0, 32'h0000_80FF);
        load(32'h14, SIZE_WORD, 1'b0, 32'h80FF_7F00);
        load(32'h14, 2'b11,     1'b1, 32'h80FF_7F00);
        idle();
        @(negedge clk);
        check("idle_ram_ena", {31'b0, ram_ena}, 32'd0);

        // SB read-modify-write
        store_sub(32'h11, SIZE_BYTE, 32'h0000_00AA);
        idle();
        check("sb_word4", mem[4], 32'h1122_AA44);
        check("sb_word3", mem[3], 32'hA500_0003);
        check("sb_word5", mem[5], 32'h80FF_7F00);

        // SW then LW back-to-back; the monitor flags any resp after the SW
        store_word(32'h20, 32'hDEAD_BEEF);
        load(32'h20, SIZE_WORD, 1'b0, 32'hDEAD_BEEF);
        idle();
        check("sw_word8", mem[8], 32'hDEAD_BEEF);

`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = SIZE_WORD;
        req_addr  = 32'h22;
        #1;
        check("mis_ram_ena", {31'b0, ram_ena}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("mis_flag", {31'b0, misalign}, 32'd1);
        check("mis_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        check("mis_flag_clear", {31'b0, misalign}, 32'd0);
`else
        load(32'h22, SIZE_WORD, 1'b0, 32'hDEAD_BEEF);
        load(32'h17, SIZE_HALF, 1'b1, 32'hFFFF_80FF);
        idle();
        @(negedge clk);
        check("nomis_flag", {31'b0, misalign}, 32'd0);
`endif

        // Reset during RMW_RD of SH 0xBEEF to 0x12 abandons the merge
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SIZE_HALF;
        req_addr  = 32'h12;
        req_wdata = 32'h0000_BEEF;
        @(negedge clk);
        check("sh_in_rmw_rd", {30'b0, dbg_state}, {30'b0, RMW_RD});
        rst = 1'b1;
        #1;
        check("mid_rst_state",      {30'b0, dbg_state},  {30'b0, IDLE});
        check("mid_rst_stall",      {31'b0, stall},      32'd0);
        check("mid_rst_ram_ena",    {31'b0, ram_ena},    32'd0);
        check("mid_rst_ram_wena",   {31'b0, ram_wena},   32'd0);
        check("mid_rst_ram_wdata",  ram_wdata,           32'd0);
        check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("mid_rst_resp_rdata", resp_rdata,          32'd0);
        check("mid_rst_misalign",   {31'b0, misalign},   32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_word4", mem[4], 32'h1122_AA44);
        check("post_rst_state", {30'b0, dbg_state}, {30'b0, IDLE});

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
